sample_fifo: RTL and testbench

SAMPLE_FIFO -- requirements
Module: sample_fifo

---
 rtl/sample_fifo_pkg.sv | 17 +
 rtl/sample_fifo_ram.sv | 34 +++
 rtl/sample_fifo.sv | 167 ++++++++++++++++
 tb/tb_sample_fifo.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_fifo_pkg.sv
// Shared definitions for the sample FIFO: level/threshold sizing and the DEPTH legality check.
package sample_fifo_pkg;

    localparam int DEFAULT_DEPTH = 256;

    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Level type for the default depth; other depths derive theirs with lvl_width().
    typedef logic [lvl_width(DEFAULT_DEPTH)-1:0] level_t;

    function automatic bit depth_ok(input int depth);
        return (depth >= 4) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/sample_fifo_ram.sv
// Simple dual-port sample store: one write port, one registered read port, array never reset.
module sample_fifo_ram #(
    parameter  int DATA_WIDTH = 24,
    parameter  int DEPTH      = 256,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register holds its word until the next read; it is the standard-mode output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sample_fifo.sv
// Sample FIFO with selectable first-word-fall-through or standard read interface,
// level/threshold status and sticky overflow/underflow flags.
module sample_fifo
    import sample_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 24,
    parameter  int DEPTH      = 256,
    parameter  int FWFT       = 1,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic [ADDR_WIDTH:0]   level,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
);

    typedef logic [lvl_width(DEPTH)-1:0] lvl_t;
    localparam lvl_t LVL_FULL = lvl_t'(DEPTH);

    if (!depth_ok(DEPTH)) begin : g_depth_check
        $error("sample_fifo: DEPTH must be a power of two and at least 4");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ram_re;
    logic [DATA_WIDTH-1:0] ram_dout;

    assign full         = (level == LVL_FULL);
    assign almost_full  = (level >= af_thresh);
    assign almost_empty = (level <= ae_thresh);
    assign wr_acc       = wr_en && !full && !flush;

    sample_fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_acc),
        .wr_addr(wr_ptr),
        .wr_data(wr_data),
        .rd_en  (ram_re),
        .rd_addr(rd_ptr),
        .rd_data(ram_dout)
    );

    // Pointers and occupancy; rd_ptr advances on every RAM fetch, level on accepted ops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ram_re) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky error flags: a new event beats a simultaneous clear; flush freezes both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!flush) begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        logic                  ram_vld_p1;
        logic                  out_vld_p2;
        logic [DATA_WIDTH-1:0] out_data_p2;
        logic                  out_load;
        lvl_t                  mem_cnt;

        // Words still in the array = level minus whatever sits in the two prefetch stages.
        always_comb begin
            rd_acc   = rd_en && out_vld_p2 && !flush;
            out_load = ram_vld_p1 && (!out_vld_p2 || rd_acc);
            mem_cnt  = level - lvl_t'(ram_vld_p1) - lvl_t'(out_vld_p2);
            ram_re   = (mem_cnt != '0) && (!ram_vld_p1 || out_load) && !flush;
        end

        // Stage p1 is the RAM read register, stage p2 the presented head word.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ram_vld_p1  <= 1'b0;
                out_vld_p2  <= 1'b0;
                out_data_p2 <= '0;
            end else if (flush) begin
                ram_vld_p1  <= 1'b0;
                out_vld_p2  <= 1'b0;
                out_data_p2 <= '0;
            end else begin
                ram_vld_p1 <= ram_re || (ram_vld_p1 && !out_load);
                out_vld_p2 <= ram_vld_p1 || (out_vld_p2 && !rd_acc);
                if (out_load) begin
                    out_data_p2 <= ram_dout;
                end
            end
        end

        assign rd_data  = out_data_p2;
        assign rd_valid = out_vld_p2;
        assign empty    = !out_vld_p2;
    end else begin : g_std
        logic vld_p1;

        always_comb begin
            rd_acc = rd_en && (level != '0) && !flush;
            ram_re = rd_acc;
        end

        // The RAM read register is the output; vld_p1 marks the cycle it was refreshed.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_p1 <= 1'b0;
            end else begin
                vld_p1 <= rd_acc;
            end
        end

        assign rd_data  = ram_dout;
        assign rd_valid = vld_p1;
        assign empty    = (level == '0);
    end

endmodule

// File: tb/tb_sample_fifo.sv
// Self-checking bench for sample_fifo: FWFT and standard instances at DEPTH=8, DATA_WIDTH=24.
module tb_sample_fifo;

    localparam int DW = 24;
    localparam int D  = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          flush, wr_en, rd_en, clr_err;
    logic [DW-1:0] wr_data, rd_data;
    logic          full, almost_full, rd_valid, empty, almost_empty, overflow, underflow;
    logic [AW:0]   af_thresh, ae_thresh, level;

    logic          s_flush, s_wr_en, s_rd_en, s_clr_err;
    logic [DW-1:0] s_wr_data, s_rd_data;
    logic          s_full, s_almost_full, s_rd_valid, s_empty, s_almost_empty, s_overflow, s_underflow;
    logic [AW:0]   s_level;

    sample_fifo #(.DATA_WIDTH(DW), .DEPTH(D), .FWFT(1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .empty(empty), .almost_empty(almost_empty),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .level(level),
        .clr_err(clr_err), .overflow(overflow), .underflow(underflow)
    );

    sample_fifo #(.DATA_WIDTH(DW), .DEPTH(D), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .flush(s_flush), .wr_en(s_wr_en), .wr_data(s_wr_data),
        .full(s_full), .almost_full(s_almost_full), .rd_en(s_rd_en), .rd_data(s_rd_data),
        .rd_valid(s_rd_valid), .empty(s_empty), .almost_empty(s_almost_empty),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .level(s_level),
        .clr_err(s_clr_err), .overflow(s_overflow), .underflow(s_underflow)
    );

    int n_chk = 0;
    int n_bad = 0;
    logic [DW-1:0] sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_write(input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        sb.push_back(d);
    endtask

    // Compare the presented head against the scoreboard, then acknowledge it.
    task automatic read_head(input string tag);
        logic [DW-1:0] exp_d;
        check({tag, "_vld"}, rd_valid, 1'b1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1'b1, 1'b0);
        end else begin
            exp_d = sb.pop_front();
            check({tag, "_data"}, rd_data, exp_d);
        end
        rd_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] exp_d;
        rst = 1'b1;
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
        s_flush = 1'b0; s_wr_en = 1'b0; s_rd_en = 1'b0; s_clr_err = 1'b0; s_wr_data = '0;
        af_thresh = 4'd6;
        ae_thresh = 4'd2;
        @(negedge clk);
        @(negedge clk);

        check("rst_empty", empty, 1'b1);
        check("rst_aempty", almost_empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_level", level, 0);
        check("rst_rdvalid", rd_valid, 1'b0);
        check("rst_rddata", rd_data, 0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_unf", underflow, 1'b0);
        check("rst_s_empty", s_empty, 1'b1);
        check("rst_s_rdvalid", s_rd_valid, 1'b0);
        check("rst_s_rddata", s_rd_data, 0);
        rst = 1'b0;
        tick();

        // Fill with 1..8, thresholds observed on the way up.
        for (int i = 1; i <= 8; i++) begin
            push_write(DW'(i));
            tick();
            check("fill_level", level, i);
            check("fill_af", almost_full, (i >= 6));
            check("fill_ae", almost_empty, (i <= 2));
        end
        check("fill_full", full, 1'b1);
        wr_data = 24'h000009;
        tick();
        wr_en = 1'b0;
        check("ovf_set", overflow, 1'b1);
        check("ovf_level", level, 8);
        check("ovf_full", full, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) begin
            read_head("drain");
            tick();
        end
        rd_en = 1'b0;
        check("drain_empty", empty, 1'b1);
        check("drain_level", level, 0);
        check("drain_rdvalid", rd_valid, 1'b0);
        check("drain_unf", underflow, 1'b0);

        // First-word latency into an empty FIFO.
        push_write(24'hABCDEF);
        tick();
        wr_en = 1'b0;
        check("lat1_level", level, 1);
        check("lat1_empty", empty, 1'b1);
        tick();
        check("lat2_rdvalid", rd_valid, 1'b0);
        tick();
        check("lat3_empty", empty, 1'b0);
        read_head("lat3");
        tick();
        rd_en = 1'b0;
        check("lat_after_empty", empty, 1'b1);

        // Steady state at level 4 with concurrent read and write.
        for (int i = 0; i < 4; i++) begin
            push_write(DW'(24'h000100 + i));
            tick();
        end
        wr_en = 1'b0;
        tick();
        tick();
        check("sim_start_level", level, 4);
        for (int i = 0; i < 20; i++) begin
            read_head("sim");
            push_write(DW'(24'h000200 + i));
            tick();
            check("sim_level", level, 4);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            read_head("sim_drain");
            tick();
        end
        rd_en = 1'b0;
        check("sim_end_empty", empty, 1'b1);

        // Flush with a simultaneous write at level 5, then clear the sticky flag.
        for (int i = 0; i < 5; i++) begin
            push_write(DW'(24'h000300 + i));
            tick();
        end
        wr_en = 1'b0;
        tick();
        tick();
        check("fl_pre_level", level, 5);
        flush = 1'b1;
        wr_en = 1'b1;
        wr_data = 24'h0003FF;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        sb.delete();
        check("fl_level", level, 0);
        check("fl_empty", empty, 1'b1);
        check("fl_rdvalid", rd_valid, 1'b0);
        check("fl_ovf_kept", overflow, 1'b1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_ovf", overflow, 1'b0);

        // Post-flush round trip, underflow and set-over-clear priority.
        push_write(24'h000777);
        tick();
        wr_en = 1'b0;
        tick();
        tick();
        read_head("pf");
        tick();
        check("pf_empty", empty, 1'b1);
        tick();
        check("unf_set", underflow, 1'b1);
        clr_err = 1'b1;
        tick();
        check("unf_set_wins", underflow, 1'b1);
        rd_en = 1'b0;
        tick();
        clr_err = 1'b0;
        check("unf_cleared", underflow, 1'b0);

        // Standard mode: one-cycle valid pulse, held data, underflow on second read.
        s_wr_en = 1'b1;
        s_wr_data = 24'h111111;
        sb.push_back(24'h111111);
        tick();
        s_wr_en = 1'b0;
        check("std_level", s_level, 1);
        check("std_empty", s_empty, 1'b0);
        check("std_rdvalid_idle", s_rd_valid, 1'b0);
        s_rd_en = 1'b1;
        tick();
        check("std_rdvalid", s_rd_valid, 1'b1);
        if (sb.size() == 0) begin
            check("std_sb_empty", 1'b1, 1'b0);
        end else begin
            exp_d = sb.pop_front();
            check("std_rddata", s_rd_data, exp_d);
        end
        check("std_empty_after", s_empty, 1'b1);
        tick();
        s_rd_en = 1'b0;
        check("std_unf", s_underflow, 1'b1);
        check("std_pulse_end", s_rd_valid, 1'b0);
        tick();
        check("std_hold", s_rd_data, 24'h111111);
        check("std_ovf", s_overflow, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
